// File: rtl/alu_exec_if.sv
// Operand/control and result bundle for the execute-stage ALU.
// The master drives operands and the op select; the slave returns the registered result.
interface alu_exec_if #(
   parameter int unsigned WIDTH = 32
);
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] test_a;
   logic [WIDTH-1:0] test_b;
   logic [WIDTH-1:0] alu_result;
   logic             zero;

   modport master (
      output alu_ctrl,
      output test_a,
      output test_b,
      input  alu_result,
      input  zero
   );

   modport slave (
      input  alu_ctrl,
      input  test_a,
      input  test_b,
      output alu_result,
      output zero
   );
endinterface

// File: rtl/alu_exec_top.sv
// 32-bit integer ALU with a single registered result stage and zero flag.
// Operands and op select come straight from the interface; a result appears one edge later.
module alu_exec_top #(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   alu_exec_if.slave bus
);
   localparam int unsigned ShW = $clog2(WIDTH);

   localparam logic [3:0] AluAdd  = 4'b0000;
   localparam logic [3:0] AluSub  = 4'b0001;
   localparam logic [3:0] AluAnd  = 4'b0010;
   localparam logic [3:0] AluOr   = 4'b0011;
   localparam logic [3:0] AluXor  = 4'b0100;
   localparam logic [3:0] AluSll  = 4'b0101;
   localparam logic [3:0] AluSrl  = 4'b0110;
   localparam logic [3:0] AluSra  = 4'b0111;
   localparam logic [3:0] AluSlt  = 4'b1000;
   localparam logic [3:0] AluSltu = 4'b1001;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [ShW-1:0]   shamt;
   logic [WIDTH-1:0] result_d, result_q;
   logic             zero_d, zero_q;

   assign a     = bus.test_a;
   assign b     = bus.test_b;
   assign shamt = b[ShW-1:0];

   always_comb begin
      result_d = '0;
      case (bus.alu_ctrl)
         AluAdd:  result_d = a + b;
         AluSub:  result_d = a - b;
         AluAnd:  result_d = a & b;
         AluOr:   result_d = a | b;
         AluXor:  result_d = a ^ b;
         AluSll:  result_d = a << shamt;
         AluSrl:  result_d = a >> shamt;
         AluSra:  result_d = $signed(a) >>> shamt;
         AluSlt:  result_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         AluSltu: result_d = {{(WIDTH-1){1'b0}}, a < b};
         default: result_d = '0;
      endcase
   end

   // Flag derives from the new result so both outputs always agree.
   assign zero_d = (result_d == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.alu_result = result_q;
   assign bus.zero       = zero_q;
endmodule

// File: tb/tb_alu_exec_top.sv
// Self-checking bench for alu_exec_top: directed cases plus a random stream
// compared against an arithmetic reference model, with mid-stream resets.
module tb_alu_exec_top;
   logic clk;
   logic reset;

   alu_exec_if #(.WIDTH(32)) bus ();

   alu_exec_top #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_res;
   logic        exp_z;
   bit          have_exp = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: shifts as multiply/divide by powers of two, compares on widened integers.
   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      longint unsigned ua  = {32'd0, a};
      longint unsigned ub  = {32'd0, b};
      longint          sa  = longint'($signed(a));
      longint          sb  = longint'($signed(b));
      longint unsigned mod = 64'h1_0000_0000;
      longint unsigned p2  = 64'd1 << (b % 32);
      longint          r;
      case (c)
         4'd0:    r = longint'((ua + ub) % mod);
         4'd1:    r = longint'((ua + mod - ub) % mod);
         4'd2:    r = longint'(ua & ub);
         4'd3:    r = longint'(ua | ub);
         4'd4:    r = longint'(ua ^ ub);
         4'd5:    r = longint'((ua * p2) % mod);
         4'd6:    r = longint'(ua / p2);
         4'd7:    r = (sa >= 0) ? sa / longint'(p2)
                                : -((-sa + longint'(p2) - 1) / longint'(p2));
         4'd8:    r = (sa < sb) ? 1 : 0;
         4'd9:    r = (ua < ub) ? 1 : 0;
         default: r = 0;
      endcase
      return r[31:0];
   endfunction

   // One operation per clock: before the edge the old result must still hold,
   // after the edge the new one must be visible.
   task automatic step(input logic r, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
      @(negedge clk);
      reset        = r;
      bus.alu_ctrl = c;
      bus.test_a   = a;
      bus.test_b   = b;
      if (have_exp) begin
         #1;
         check({tag, " hold"}, bus.alu_result, exp_res);
      end
      exp_res  = r ? 32'd0 : ref_alu(c, a, b);
      exp_z    = (exp_res == 32'd0);
      have_exp = 1'b1;
      @(posedge clk);
      #1;
      check(tag, bus.alu_result, exp_res);
      check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, exp_z});
   endtask

   task automatic dir(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lit, input string tag);
      step(1'b0, c, a, b, tag);
      check({tag, " const"}, bus.alu_result, lit);
      check({tag, " const zero"}, {31'd0, bus.zero}, {31'd0, lit == 32'd0});
   endtask

   initial begin
      reset        = 1'b1;
      bus.alu_ctrl = 4'bxxxx;
      bus.test_a   = 32'hxxxx_xxxx;
      bus.test_b   = 32'hxxxx_xxxx;
      step(1'b1, 4'bxxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, "reset");
      check("reset const", bus.alu_result, 32'd0);
      check("reset const zero", {31'd0, bus.zero}, 32'd1);

      dir(4'd0, 32'd10,        32'd15,        32'h0000_0019, "add");
      dir(4'd1, 32'd10,        32'd15,        32'hFFFF_FFFB, "sub");
      dir(4'd0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, "add wrap");
      dir(4'd2, 32'd10,        32'd15,        32'd10,        "and");
      dir(4'd3, 32'd10,        32'd15,        32'd15,        "or");
      dir(4'd4, 32'd10,        32'd15,        32'd5,         "xor");
      dir(4'd4, 32'h1234_5678, 32'h1234_5678, 32'd0,         "xor self");
      dir(4'd5, 32'd10,        32'd15,        32'h0005_0000, "sll");
      dir(4'd6, 32'd10,        32'd15,        32'd0,         "srl");
      dir(4'd6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, "srl hi");
      dir(4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra hi");
      dir(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, "sll by 0");
      dir(4'd8, 32'hFFFF_FFFF, 32'd1,         32'd1,         "slt");
      dir(4'd9, 32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu");
      dir(4'd8, 32'd7,         32'd7,         32'd0,         "slt eq");
      for (int c = 10; c < 16; c++) begin
         dir(c[3:0], 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, $sformatf("unused %0d", c));
      end

      // Reset in the middle of a stream discards the operation at that edge.
      step(1'b0, 4'd3, 32'hA5A5_0000, 32'h0000_5A5A, "stream or");
      step(1'b1, 4'd0, 32'h1111_1111, 32'h2222_2222, "stream reset");
      check("stream reset const", bus.alu_result, 32'd0);
      step(1'b0, 4'd1, 32'd100, 32'd1, "stream sub");

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [3:0]  c;
         logic        r;
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: b = a;
            1: a = {a[31], 31'd0} | (a & 32'h0000_00FF);
            default: ;
         endcase
         r = ($urandom_range(0, 24) == 0);
         step(r, c, a, b, $sformatf("rand %0d op %0d", i, c));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_exec_top.md
Name: alu_exec_top

Overview:
- Top-level wrapper around a 32-bit integer ALU with a registered result stage, used to exercise ALU operations directly from external operand and control pins.
- Each clock edge samples `test_a`, `test_b` and `alu_ctrl`, computes the operation and registers the 32-bit result and a zero flag.
- Sits at the execute-stage position of the single-cycle RISC-V datapath; in this configuration the operands come straight from the ports.

Parameters:
- WIDTH, 32, datapath width of operands and result. Only 32 is required to be supported.

Ports:
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `alu_ctrl` input 4: operation select (encoding below).
- `test_a` input 32: operand A.
- `test_b` input 32: operand B; for shifts, shift amount = `test_b[4:0]`.
- `alu_result` output 32: registered ALU result.
- `zero` output 1: registered flag, high when `alu_result` == 0.

Behaviour:
- Reset:
  - On any rising edge with `reset`=1: `alu_result` <= 0 and `zero` <= 1.
  - Inputs are ignored during reset, even if X/undefined.
  - Reset asserted mid-operation discards the pending computation at that edge.
- Latency:
  - Combinational compute from the current `test_a`, `test_b` and `alu_ctrl`.
  - The result is registered on the next rising edge, so outputs reflect inputs present one clock earlier.
  - No handshake; a new operation is accepted every cycle.
- Operation encoding of `alu_ctrl`:
  - 0000 ADD: A + B, modulo 2^32, carry discarded.
  - 0001 SUB: A - B, modulo 2^32 (two's complement wrap).
  - 0010 AND: A & B.
  - 0011 OR: A | B.
  - 0100 XOR: A ^ B.
  - 0101 SLL: A << B[4:0], zero fill.
  - 0110 SRL: A >> B[4:0], logical, zero fill.
  - 0111 SRA: arithmetic right shift of A by B[4:0], sign fill.
  - 1000 SLT: 32'd1 if signed(A) < signed(B), else 0.
  - 1001 SLTU: 32'd1 if unsigned(A) < unsigned(B), else 0.
  - 1010–1111: result = 0, which sets `zero`.
- Shift rules:
  - Bits B[31:5] are ignored.
  - A shift amount of 0 returns A unchanged.
- Zero flag:
  - `zero` is registered in the same edge as `alu_result`.
  - It is computed from the new result, so the two outputs are always mutually consistent.
- Overflow: no overflow or carry output exists; ADD/SUB wrap silently.
- Storage: no other state; the design is one 33-bit register stage plus combinational logic.

Test Plan:
- Reset: hold `reset`=1 for one edge with operands X -> `alu_result`=0x00000000, `zero`=1; release reset.
- Arithmetic, A=10, B=15, one edge per op:
  - ADD -> 25 (0x00000019), `zero`=0.
  - SUB -> 0xFFFFFFFB, `zero`=0.
  - Wrap case A=0xFFFFFFFF, B=1, ADD -> 0, `zero`=1.
- Logic, A=10, B=15:
  - AND -> 10.
  - OR -> 15.
  - XOR -> 5.
  - A=B=0x12345678, XOR -> 0, `zero`=1.
- Shifts, A=10, B=15:
  - SLL -> 0x00050000.
  - SRL -> 0, `zero`=1.
  - A=0x80000000, B=0x00000024 (amount 4): SRL -> 0x08000000; SRA -> 0xF8000000.
- Compares:
  - A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0.
  - A=B=7: SLT -> 0, `zero`=1.
- Latency and reset: change `alu_ctrl` every cycle and check each result appears exactly one edge later. Assert `reset` during a stream -> next edge gives `alu_result`=0, `zero`=1. Unused codes 1010–1111 -> result 0, `zero`=1.
